// File: rtl/ysyx_25030085_lsu.sv
// ysyx_25030085_lsu -- load/store unit in front of the data memory.
//
// Takes one decoded memory operation at a time from EXU and turns it into a
// word-aligned memory request with a byte mask and lane-replicated store
// data. Load responses are byte/half extracted and sign/zero-extended before
// going to WBU. Misaligned accesses, illegal MemOp codes and memory timeouts
// complete without (or abandon) the memory request and are flagged on the
// result.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready        operation from EXU (MemRead, MemWrite, MemOp,
//                            addr, Read_rs2); in_ready only in IDLE
//   mem_req/mem_gnt          request to memory with mem_we, mem_addr,
//                            mem_wdata, mem_wmask
//   mem_rvalid, mem_rdata    read response
//   out_valid/out_ready      result to WBU: ReadData, misalign, fault
//   state_dbg                current FSM state (IDLE=0, REQ=1, WAIT=2, DONE=3)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid keeps its payload stable until that
// edge; ready may change freely. mem_req/mem_gnt follow the same rule, with
// mem_req dropping in the cycle after the grant. mem_rvalid has no ready and
// is only consumed while waiting for load data.

module ysyx_25030085_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  MemOp,
  input  logic [31:0] addr,
  input  logic [31:0] Read_rs2,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] ReadData,
  output logic        misalign,
  output logic        fault,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  op_r, op_n;
  logic [1:0]  off_r, off_n;

  logic        mem_req_n, mem_we_n, out_valid_n, misalign_n, fault_n;
  logic [31:0] mem_addr_n, mem_wdata_n, read_data_n;
  logic [3:0]  mem_wmask_n;

  // Decode of the operation currently offered on the input side.
  logic        is_load, is_store, op_bad, op_mis;
  logic [3:0]  lane_mask;
  logic [31:0] lane_data;
  // Load extraction of the response word, using the registered op/offset.
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ld_data;
  logic [16:0] cnt_inc;
  logic        cnt_hit;

  assign in_ready  = (state == IDLE) && rst;
  assign state_dbg = state;

  always_comb begin
    is_load  = MemRead;
    is_store = MemWrite && !MemRead;   // load wins when both are set
    if (is_load) op_bad = (MemOp == 3'b011) || (MemOp[2:1] == 2'b11);
    else         op_bad = is_store && (MemOp[2] || (MemOp == 3'b011));
    op_mis = ((MemOp[1:0] == 2'b01) && addr[0]) ||
             ((MemOp[1:0] == 2'b10) && (addr[1:0] != 2'b00));

    case (MemOp[1:0])
      2'b00: begin
        lane_mask = 4'b0001 << addr[1:0];
        lane_data = {4{Read_rs2[7:0]}};
      end
      2'b01: begin
        lane_mask = 4'b0011 << addr[1:0];
        lane_data = {2{Read_rs2[15:0]}};
      end
      default: begin
        lane_mask = 4'b1111;
        lane_data = Read_rs2;
      end
    endcase
  end

  always_comb begin
    rd_byte = mem_rdata[{off_r, 3'b000} +: 8];
    rd_half = mem_rdata[{off_r[1], 4'b0000} +: 16];
    case (op_r)
      3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
      3'b100:  ld_data = {24'd0, rd_byte};
      3'b101:  ld_data = {16'd0, rd_half};
      default: ld_data = mem_rdata;
    endcase
  end

  // cnt counts cycles already spent in REQ/WAIT; cnt_hit is true on the
  // edge that would make the count reach TIMEOUT.
  assign cnt_inc = {1'b0, cnt} + 17'd1;
  assign cnt_hit = (cnt_inc == 17'(TIMEOUT));

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    op_n        = op_r;
    off_n       = off_r;
    mem_req_n   = mem_req;
    mem_we_n    = mem_we;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    mem_wmask_n = mem_wmask;
    out_valid_n = out_valid;
    read_data_n = ReadData;
    misalign_n  = misalign;
    fault_n     = fault;

    case (state)
      IDLE: begin
        if (in_valid) begin
          cnt_n       = 16'd0;
          op_n        = MemOp;
          off_n       = addr[1:0];
          read_data_n = 32'd0;
          misalign_n  = 1'b0;
          fault_n     = 1'b0;
          state_n     = DONE;
          out_valid_n = 1'b1;
          if (!is_load && !is_store) begin
            // no memory operation: complete with zero result
          end else if (op_bad) begin
            fault_n = 1'b1;
          end else if (op_mis) begin
            misalign_n = 1'b1;
          end else begin
            state_n     = REQ;
            out_valid_n = 1'b0;
            mem_req_n   = 1'b1;
            mem_we_n    = is_store;
            mem_addr_n  = {addr[31:2], 2'b00};
            mem_wdata_n = lane_data;
            mem_wmask_n = lane_mask;
          end
        end
      end

      REQ: begin
        cnt_n = cnt_inc[15:0];
        if (mem_gnt) begin
          mem_req_n = 1'b0;
          if (mem_we) begin
            state_n     = DONE;
            out_valid_n = 1'b1;
          end else begin
            state_n = WAIT;
          end
        end else if (cnt_hit) begin
          mem_req_n   = 1'b0;
          state_n     = DONE;
          out_valid_n = 1'b1;
          fault_n     = 1'b1;
          read_data_n = 32'd0;
        end
      end

      WAIT: begin
        cnt_n = cnt_inc[15:0];
        if (mem_rvalid) begin
          state_n     = DONE;
          out_valid_n = 1'b1;
          read_data_n = ld_data;
        end else if (cnt_hit) begin
          state_n     = DONE;
          out_valid_n = 1'b1;
          fault_n     = 1'b1;
          read_data_n = 32'd0;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_n     = IDLE;
          out_valid_n = 1'b0;
          read_data_n = 32'd0;
          misalign_n  = 1'b0;
          fault_n     = 1'b0;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 16'd0;
      op_r      <= 3'd0;
      off_r     <= 2'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_wmask <= 4'd0;
      out_valid <= 1'b0;
      ReadData  <= 32'd0;
      misalign  <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      op_r      <= op_n;
      off_r     <= off_n;
      mem_req   <= mem_req_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      mem_wmask <= mem_wmask_n;
      out_valid <= out_valid_n;
      ReadData  <= read_data_n;
      misalign  <= misalign_n;
      fault     <= fault_n;
    end
  end

endmodule

// File: tb/tb_ysyx_25030085_lsu.sv
// Testbench for ysyx_25030085_lsu: directed scenarios with hand-computed
// expected values. Inputs change and outputs are sampled on the falling edge.

module tb_ysyx_25030085_lsu;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  MemOp;
  logic [31:0] addr;
  logic [31:0] Read_rs2;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ReadData;
  logic        misalign;
  logic        fault;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  ysyx_25030085_lsu #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemOp(MemOp),
    .addr(addr), .Read_rs2(Read_rs2),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .ReadData(ReadData), .misalign(misalign), .fault(fault),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Offer one operation for a single accept edge; returns at the falling
  // edge right after the accept edge (cycle 1).
  task automatic issue(input logic rd, input logic wr, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] d);
    in_valid = 1'b1; MemRead = rd; MemWrite = wr; MemOp = op;
    addr = a; Read_rs2 = d;
    @(negedge clk);
    in_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; MemOp = 3'd0;
    addr = 32'd0; Read_rs2 = 32'd0;
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || mem_req !== 1'b0 || out_valid !== 1'b0 || ReadData !== 32'd0 ||
        mem_addr !== 32'd0 || mem_wmask !== 4'd0 || mem_wdata !== 32'd0 || mem_we !== 1'b0 ||
        misalign !== 1'b0 || fault !== 1'b0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_held: in_ready=%b req=%b ov=%b rd=%h addr=%h mask=%b st=%0d, expected all 0",
               in_ready, mem_req, out_valid, ReadData, mem_addr, mem_wmask, state_dbg);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b expected 1", in_ready);
    end
  endtask

  task automatic run_load(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] rd, input logic [31:0] exp);
    issue(1'b1, 1'b0, op, a, 32'h5555_5555);
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== {a[31:2], 2'b00} || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_req: req=%b we=%b addr=%h in_ready=%b, expected req=1 we=0 addr=%h in_ready=0",
               name, mem_req, mem_we, mem_addr, in_ready, {a[31:2], 2'b00});
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_wait: req=%b ov=%b, expected req=0 ov=0", name, mem_req, out_valid);
    end
    mem_rvalid = 1'b1; mem_rdata = rd;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = 32'd0;
    checks++;
    if (out_valid !== 1'b1 || ReadData !== exp || fault !== 1'b0 || misalign !== 1'b0) begin
      errors++;
      $display("FAIL %s_data: ov=%b rd=%h fault=%b mis=%b, expected ov=1 rd=%h fault=0 mis=0",
               name, out_valid, ReadData, fault, misalign, exp);
    end
    retire();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_retire: ov=%b in_ready=%b, expected 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_loads();
    run_load("lb",  3'b000, 32'h0000_1003, 32'h80FF_1234, 32'hFFFF_FF80);
    run_load("lbu", 3'b100, 32'h0000_1003, 32'h80FF_1234, 32'h0000_0080);
    run_load("lb1", 3'b000, 32'h0000_1001, 32'h80FF_1234, 32'h0000_0012);
    run_load("lh",  3'b001, 32'h0000_1002, 32'h80FF_1234, 32'hFFFF_80FF);
    run_load("lhu", 3'b101, 32'h0000_1002, 32'h80FF_1234, 32'h0000_80FF);
    run_load("lh0", 3'b001, 32'h0000_1000, 32'h80FF_9234, 32'hFFFF_9234);
    run_load("lw",  3'b010, 32'h0000_1004, 32'h80FF_1234, 32'h80FF_1234);
  endtask

  task automatic run_store(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] exp_mask,
                           input logic [31:0] exp_data);
    issue(1'b0, 1'b1, op, a, d);
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== {a[31:2], 2'b00} ||
        mem_wmask !== exp_mask || mem_wdata !== exp_data) begin
      errors++;
      $display("FAIL %s_req: req=%b we=%b addr=%h mask=%b data=%h, expected 1 1 %h %b %h",
               name, mem_req, mem_we, mem_addr, mem_wmask, mem_wdata,
               {a[31:2], 2'b00}, exp_mask, exp_data);
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || mem_req !== 1'b0 || ReadData !== 32'd0 || fault !== 1'b0 ||
        misalign !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: ov=%b req=%b rd=%h fault=%b mis=%b, expected 1 0 0 0 0",
               name, out_valid, mem_req, ReadData, fault, misalign);
    end
    retire();
  endtask

  task automatic test_stores();
    run_store("sh", 3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 4'b1100, 32'hBEEF_BEEF);
    run_store("sb", 3'b000, 32'h0000_2001, 32'h1234_56A5, 4'b0010, 32'hA5A5_A5A5);
    run_store("sb3", 3'b000, 32'h0000_2003, 32'h0000_007E, 4'b1000, 32'h7E7E_7E7E);
    run_store("sw", 3'b010, 32'h0000_2004, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
  endtask

  // Operations that complete without touching memory.
  task automatic run_reject(input string name, input logic rd, input logic wr,
                            input logic [2:0] op, input logic [31:0] a,
                            input logic exp_mis, input logic exp_fault);
    issue(rd, wr, op, a, 32'hFFFF_FFFF);
    checks++;
    if (mem_req !== 1'b0 || out_valid !== 1'b1 || misalign !== exp_mis || fault !== exp_fault ||
        ReadData !== 32'd0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s: req=%b ov=%b mis=%b fault=%b rd=%h in_ready=%b, expected 0 1 %b %b 0 0",
               name, mem_req, out_valid, misalign, fault, ReadData, in_ready, exp_mis, exp_fault);
    end
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_hold: req=%b ov=%b, expected 0 1", name, mem_req, out_valid);
    end
    retire();
  endtask

  task automatic test_rejects();
    run_reject("lw_misalign",  1'b1, 1'b0, 3'b010, 32'h0000_3001, 1'b1, 1'b0);
    run_reject("lw_misalign2", 1'b1, 1'b0, 3'b010, 32'h0000_3002, 1'b1, 1'b0);
    run_reject("lhu_misalign", 1'b1, 1'b0, 3'b101, 32'h0000_3003, 1'b1, 1'b0);
    run_reject("sh_misalign",  1'b0, 1'b1, 3'b001, 32'h0000_3001, 1'b1, 1'b0);
    run_reject("ld_op011",     1'b1, 1'b0, 3'b011, 32'h0000_3000, 1'b0, 1'b1);
    run_reject("ld_op110",     1'b1, 1'b0, 3'b110, 32'h0000_3000, 1'b0, 1'b1);
    run_reject("st_op100",     1'b0, 1'b1, 3'b100, 32'h0000_3000, 1'b0, 1'b1);
    run_reject("st_op101",     1'b0, 1'b1, 3'b101, 32'h0000_3001, 1'b0, 1'b1);
    run_reject("no_op",        1'b0, 1'b0, 3'b010, 32'h0000_3000, 1'b0, 1'b0);
  endtask

  task automatic test_read_priority();
    issue(1'b1, 1'b1, 3'b010, 32'h0000_6000, 32'h1111_1111);
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL read_priority: req=%b we=%b, expected 1 0", mem_req, mem_we);
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_CAFE;
    @(negedge clk);
    mem_rvalid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || ReadData !== 32'h0BAD_CAFE) begin
      errors++;
      $display("FAIL read_priority_data: ov=%b rd=%h, expected 1 0badcafe", out_valid, ReadData);
    end
    retire();
  endtask

  task automatic test_gnt_stall();
    issue(1'b1, 1'b0, 3'b010, 32'h0000_4008, 32'd0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h0000_4008 || mem_wmask !== 4'b1111 || mem_we !== 1'b0) begin
        errors++;
        $display("FAIL gnt_stall_%0d: req=%b addr=%h mask=%b we=%b, expected 1 00004008 1111 0",
                 i, mem_req, mem_addr, mem_wmask, mem_we);
      end
      @(negedge clk);
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h7654_3210;
    @(negedge clk);
    mem_rvalid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || ReadData !== 32'h7654_3210 || fault !== 1'b0) begin
      errors++;
      $display("FAIL gnt_stall_done: ov=%b rd=%h fault=%b, expected 1 76543210 0",
               out_valid, ReadData, fault);
    end
    retire();
  endtask

  task automatic test_timeout();
    issue(1'b1, 1'b0, 3'b010, 32'h0000_7000, 32'd0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (mem_req !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL timeout_wait_%0d: req=%b ov=%b, expected 1 0", i, mem_req, out_valid);
      end
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b1 || fault !== 1'b1 || mem_req !== 1'b0 || ReadData !== 32'd0) begin
      errors++;
      $display("FAIL timeout_fault: ov=%b fault=%b req=%b rd=%h, expected 1 1 0 0",
               out_valid, fault, mem_req, ReadData);
    end
    retire();
    // A timeout while waiting for load data behaves the same way.
    issue(1'b1, 1'b0, 3'b000, 32'h0000_7001, 32'd0);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    for (int i = 0; i < 7; i++) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || fault !== 1'b1 || ReadData !== 32'd0) begin
      errors++;
      $display("FAIL timeout_wait_fault: ov=%b fault=%b rd=%h, expected 1 1 0",
               out_valid, fault, ReadData);
    end
    retire();
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 1'b0, 3'b100, 32'h0000_1003, 32'd0);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h80FF_1234;
    @(negedge clk);
    mem_rvalid = 1'b0;
    // keep a new operation offered while the result waits
    in_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; MemOp = 3'b010;
    addr = 32'h0000_5000; Read_rs2 = 32'h0102_0304;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || ReadData !== 32'h0000_0080 || in_ready !== 1'b0 || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d: ov=%b rd=%h in_ready=%b req=%b, expected 1 00000080 0 0",
                 i, out_valid, ReadData, in_ready, mem_req);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || mem_req !== 1'b0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL release_idle: ov=%b in_ready=%b req=%b st=%0d, expected 0 1 0 0",
               out_valid, in_ready, mem_req, state_dbg);
    end
    @(negedge clk);
    in_valid = 1'b0; MemWrite = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h0000_5000 || mem_wdata !== 32'h0102_0304) begin
      errors++;
      $display("FAIL next_accept: req=%b we=%b addr=%h data=%h, expected 1 1 00005000 01020304",
               mem_req, mem_we, mem_addr, mem_wdata);
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    retire();
  endtask

  task automatic test_reset_mid();
    // reset while the request is outstanding: mem_req drops at once
    issue(1'b1, 1'b0, 3'b010, 32'h0000_8000, 32'd0);
    rst = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_in_req: req=%b st=%0d, expected 0 0", mem_req, state_dbg);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    // reset while waiting for load data, then a stale response arrives
    issue(1'b1, 1'b0, 3'b010, 32'h0000_8004, 32'd0);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_DEAD;
    @(negedge clk);
    mem_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || ReadData !== 32'd0 || in_ready !== 1'b1 || mem_req !== 1'b0 ||
        fault !== 1'b0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL stale_rvalid: ov=%b rd=%h in_ready=%b req=%b fault=%b st=%0d, expected 0 0 1 0 0 0",
               out_valid, ReadData, in_ready, mem_req, fault, state_dbg);
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    in_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; MemOp = 3'd0;
    addr = 32'd0; Read_rs2 = 32'd0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = 32'd0; out_ready = 1'b0;
    test_reset();
    test_loads();
    test_stores();
    test_rejects();
    test_read_priority();
    test_gnt_stall();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_25030085_lsu.md
Name: ysyx_25030085_lsu

Overview:
Load/store unit sitting directly upstream of the data memory, between EXU and the memory port. It takes one decoded memory operation at a time and converts it into a word-aligned request with byte mask and lane-replicated write data. On loads it extracts and sign/zero-extends the response before handing the result to WBU. It also detects misaligned accesses, illegal MemOp codes and memory timeouts.

Parameters:
TIMEOUT, 255, max cycles spent in REQ+WAIT before fault; legal range 2..65535

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  EXU offers an operation
in_ready  out  1  LSU accepts; high only in IDLE
MemRead  in  1  load
MemWrite  in  1  store
MemOp  in  3  funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
addr  in  32  byte address (alu result)
Read_rs2  in  32  store data
mem_req  out  1  memory request valid
mem_gnt  in  1  memory accepts request
mem_we  out  1  1 = write
mem_addr  out  32  {addr[31:2],2'b00}
mem_wdata  out  32  lane-replicated store data
mem_wmask  out  4  byte-enable
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read word
out_valid  out  1  result valid to WBU
out_ready  in  1  WBU accepts
ReadData  out  32  extended load data, 0 for stores and faults
misalign  out  1  qualifies out_valid
fault  out  1  qualifies out_valid; illegal MemOp or timeout

Behaviour:
- Reset (rst low, async): state=IDLE, timeout counter=0, all registered outputs 0 (mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, out_valid, ReadData, misalign, fault). in_ready = (state==IDLE) && rst.
- Reset mid-transaction abandons it. mem_req drops immediately. A late mem_rvalid after reset is ignored.
- States: IDLE, REQ, WAIT, DONE.
- IDLE: accept on in_valid&&in_ready and register all inputs.
  - MemRead has priority when MemRead and MemWrite are both high.
  - Neither asserted -> DONE with ReadData=0.
  - Illegal MemOp (011, 110, 111; stores also reject 1xx) -> DONE with fault=1; no request issued.
  - Misaligned -> DONE with misalign=1; no request issued. Misaligned means: h/hu with addr[0]=1, or w with addr[1:0]!=0.
  - Otherwise -> REQ.
- REQ: mem_req=1. mem_addr, mem_we, mem_wdata and mem_wmask stay stable until mem_gnt.
  - On gnt, a store -> DONE and a load -> WAIT.
  - mem_req deasserts in the cycle after gnt.
- WAIT: on mem_rvalid, register extended data -> DONE. mem_rvalid in any other state is ignored.
- Timeout: counter clears on accept and increments each cycle in REQ or WAIT. When it reaches TIMEOUT: go to DONE with fault=1 and ReadData=0, and mem_req=0.
- DONE: out_valid=1 with results held stable until out_ready -> IDLE. out_valid clears the same edge. No new accept occurs in that cycle; next accept is one cycle later.
- Store lanes, with o=addr[1:0]:
  - sb: wmask=4'b0001<<o, wdata={4{rs2[7:0]}}.
  - sh: wmask=4'b0011<<o, wdata={2{rs2[15:0]}}.
  - sw: wmask=4'b1111, wdata=rs2.
- Load extract: byte = rdata[8*o+:8]; half = rdata[16*addr[1]+:16]. b/h sign-extend, bu/hu zero-extend, w passes through.
- Minimum load latency: accept edge 0, gnt in cycle 1, rvalid in cycle 2, out_valid in cycle 3. Minimum store latency: out_valid in cycle 2.
- Throughput: one operation in flight. in_ready=0 in REQ, WAIT and DONE.

Test Plan:
- lb addr=0x1003, mem_rdata=0x80FF_1234 -> ReadData=0xFFFF_FF80; lbu same -> 0x0000_0080; mem_addr=0x1000.
- sh addr=0x2002, Read_rs2=0xDEAD_BEEF -> mem_wmask=4'b1100, mem_wdata=0xBEEF_BEEF, mem_we=1; out_valid 2 cycles after accept with gnt immediate.
- lw addr=0x3001 -> no mem_req ever; out_valid with misalign=1, ReadData=0; also MemOp=3'b011 -> fault=1, no request.
- mem_gnt held low 4 cycles -> mem_addr/wmask stable throughout; then load completes. With TIMEOUT=8, gnt never arrives -> fault=1 exactly 8 cycles after entering REQ, mem_req low after.
- out_ready held low 3 cycles in DONE -> out_valid and ReadData stable, in_ready=0; release -> IDLE, next accept one cycle later.
- rst pulled low in WAIT, then released; stale mem_rvalid=1 arrives -> ignored, outputs stay 0, in_ready=1.
